// File: rtl/cpu_div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package cpu_div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, dvs};
    q_bit   = (shifted >= {1'b0, dvs});
    // remainder stays below the divisor, so WIDTH bits always hold it
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned divider: one quotient bit per cycle, then a sign-fix cycle.
module div_seq
  import cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(ITER + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   dvd_ext, dvs_ext, q_ext, r_ext;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (acc_q[WIDTH-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    acc_d       = acc_q;
    dvs_d       = dvs_q;
    orig_d      = orig_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    // one extra bit so the magnitude of the most negative value is exact
    dvd_ext = {is_signed & dividend[WIDTH-1], dividend};
    dvs_ext = {is_signed & divisor[WIDTH-1], divisor};
    q_ext   = {1'b0, acc_q};
    r_ext   = {1'b0, rem_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = WIDTH'(dvd_ext[WIDTH] ? -dvd_ext : dvd_ext);
          dvs_d   = WIDTH'(dvs_ext[WIDTH] ? -dvs_ext : dvs_ext);
          orig_d  = dividend;
          negq_d  = dvd_ext[WIDTH] ^ dvs_ext[WIDTH];
          negr_d  = dvd_ext[WIDTH];
          rem_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = step_rem;
        acc_d = {acc_q[WIDTH-2:0], step_q};
        if (cnt_q == CW'(ITER - 1)) state_d = FIX;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      FIX: begin
        if (dvs_q == '0) begin
          quotient_d  = '1;
          remainder_d = orig_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = WIDTH'(negq_q ? -q_ext : q_ext);
          remainder_d = WIDTH'(negr_q ? -r_ext : r_ext);
          dbz_d       = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      dvs_q       <= '0;
      orig_q      <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      dvs_q       <= dvs_d;
      orig_q      <= orig_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed table, handshake/reset sequences, random vs. model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t tbl[12];

  div_seq #(.WIDTH(32), .ITER(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic plus the two special rules.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  // Called #1 after a posedge; counts posedges until done is seen.
  task automatic wait_done(output int lat, output logic ok);
    lat = 0;
    ok  = 1'b1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (!done && !busy) ok = 1'b0;
    end
  endtask

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
  endtask

  task automatic run_check(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int   lat;
    logic ok;
    launch(s, a, b);
    chk({nm, " busy_after_start"}, 32'(busy), 32'd1);
    wait_done(lat, ok);
    chk({nm, " latency"}, 32'(lat), 32'd33);
    chk({nm, " busy_held"}, 32'(ok), 32'd1);
    chk({nm, " quotient"}, quotient, eq);
    chk({nm, " remainder"}, remainder, er);
    chk({nm, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
    @(posedge clk); #1;
    chk({nm, " done_one_cycle"}, 32'(done), 32'd0);
    chk({nm, " held_quotient"}, quotient, eq);
  endtask

  initial begin : main
    int   lat;
    logic ok;
    int   seen;
    logic s;
    logic [31:0] a, b, eq, er;
    logic edz;

    tbl[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    tbl[1]  = '{1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0};
    tbl[2]  = '{1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0};
    tbl[3]  = '{1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1};
    tbl[4]  = '{1'b0, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0};
    tbl[5]  = '{1'b1, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1};
    tbl[6]  = '{1'b0, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0};
    tbl[7]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
    tbl[8]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0};
    tbl[9]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0};
    tbl[10] = '{1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1};
    tbl[11] = '{1'b0, 32'd3,         32'd10,        32'd0,         32'd3,         1'b0};

    start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    reset = 1'b1;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset dbz", 32'(div_by_zero), 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_check($sformatf("tbl%0d", i), tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);

    // start re-pulsed mid-RUN with different operands must be ignored
    launch(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, ok);
    chk("repulse latency", 32'(lat), 32'd27);
    chk("repulse quotient", quotient, 32'd14);
    chk("repulse remainder", remainder, 32'd2);

    // start held across done: back-to-back operations
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    dividend = 32'd9; divisor = 32'd3;
    wait_done(lat, ok);
    chk("b2b first latency", 32'(lat), 32'd33);
    chk("b2b first quotient", quotient, 32'd14);
    chk("b2b first remainder", remainder, 32'd2);
    @(posedge clk); #1;
    chk("b2b reaccept busy", 32'(busy), 32'd1);
    chk("b2b done drop", 32'(done), 32'd0);
    start = 1'b0;
    wait_done(lat, ok);
    chk("b2b second latency", 32'(lat), 32'd33);
    chk("b2b second quotient", quotient, 32'd3);
    chk("b2b second remainder", remainder, 32'd0);

    // reset during RUN aborts; leave div_by_zero set beforehand so clearing is visible
    run_check("pre_reset dz", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
    launch(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrun reset busy", 32'(busy), 32'd0);
    chk("midrun reset done", 32'(done), 32'd0);
    chk("midrun reset dbz", 32'(div_by_zero), 32'd0);
    chk("midrun reset quotient", quotient, 32'd0);
    chk("midrun reset remainder", remainder, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("no done after reset", 32'(seen), 32'd0);
    run_check("post_reset", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      s = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       a = 32'h80000000;
        1:       a = $urandom_range(0, 50);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      ref_div(s, a, b, eq, er, edz);
      run_check($sformatf("rand%0d s=%0d %h/%h", n, s, a, b), s, a, b, eq, er, edz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
